// File: rtl/onehot_pkg.sv
// Purpose: shared mode encodings for the registered one-hot decoder/scanner.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package onehot_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DECODE = 2'b00;
  localparam mode_t MODE_SCAN   = 2'b01;
  localparam mode_t MODE_CLEAR  = 2'b10;
  localparam mode_t MODE_HOLD   = 2'b11;

endpackage

// File: rtl/onehot_dec_seq_if.sv
// Purpose: control, input and output handshake bundle of onehot_dec_seq.
// Ports: mode, in_valid/in_ready/src_num (input side), out_valid/out_ready/res_num/res_idx,
//        wrap/err pulses (output side). master = producer/consumer side, slave = the block.
interface onehot_dec_seq_if #(
  parameter int OUT_W = 8
);
  import onehot_pkg::*;

  localparam int IN_W = $clog2(OUT_W);

  mode_t            mode;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  src_num;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] res_num;
  logic [IN_W-1:0]  res_idx;
  logic             wrap;
  logic             err;

  modport master (
    output mode, in_valid, src_num, out_ready,
    input  in_ready, out_valid, res_num, res_idx, wrap, err
  );

  modport slave (
    input  mode, in_valid, src_num, out_ready,
    output in_ready, out_valid, res_num, res_idx, wrap, err
  );

endinterface

// File: rtl/onehot_dec.sv
// Purpose: combinational binary-to-one-hot decoder, OUT_W outputs, with range flag.
// Ports: idx (binary in), onehot (OUT_W bits, all-zero when idx >= OUT_W), in_range.
// Latency: 0 cycles. Backpressure: none.
module onehot_dec #(
  parameter int OUT_W = 8,
  localparam int IN_W = $clog2(OUT_W)
) (
  input  logic [IN_W-1:0]  idx,
  output logic [OUT_W-1:0] onehot,
  output logic             in_range
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (idx == IN_W'(i)) begin
        onehot[i] = 1'b1;
      end
    end
  end

  // An index past the top bit decodes to all-zero, so the OR doubles as the
  // range check and stays clean for power-of-two widths.
  assign in_range = |onehot;

endmodule

// File: rtl/onehot_dec_seq.sv
// Purpose: registered one-hot select driver: decode src_num, or round-robin scan, with clear/hold.
// Ports: clk, rst_n (async active-low), bus (slave modport: mode, in/out handshakes, res_num/res_idx, wrap/err).
// Latency: 1 cycle in->out; stalls hold the output stable; CLEAR drops a pending output.
module onehot_dec_seq
  import onehot_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  onehot_dec_seq_if.slave bus
);

  localparam int IN_W = $clog2(OUT_W);

  logic [OUT_W-1:0] cur_num, next_num, dec_onehot, rot_num;
  logic [IN_W-1:0]  cur_idx, next_idx, dec_idx;
  logic             cur_vld, next_vld;
  logic             cur_wrap, next_wrap;
  logic             cur_err, next_err;
  logic             dec_in_range;
  logic             in_rdy, accept, take_out;

  assign in_rdy   = rst_n && (bus.mode == MODE_DECODE) && (!cur_vld || bus.out_ready);
  assign accept   = bus.in_valid && in_rdy;
  assign take_out = cur_vld && bus.out_ready;
  assign rot_num  = {cur_num[OUT_W-2:0], cur_num[OUT_W-1]};

  // One decoder serves both paths: in SCAN it checks/reloads the held index,
  // otherwise it decodes the incoming src_num.
  assign dec_idx = (bus.mode == MODE_SCAN) ? cur_idx : bus.src_num;

  onehot_dec #(.OUT_W(OUT_W)) u_dec (
    .idx      (dec_idx),
    .onehot   (dec_onehot),
    .in_range (dec_in_range)
  );

  always_comb begin
    next_num  = cur_num;
    next_idx  = cur_idx;
    next_vld  = cur_vld;
    next_wrap = 1'b0;
    next_err  = 1'b0;
    case (bus.mode)
      MODE_DECODE: begin
        if (accept) begin
          next_num = dec_onehot;
          next_idx = bus.src_num;
          next_vld = 1'b1;
          next_err = !dec_in_range;
        end else if (take_out) begin
          next_vld = 1'b0;
        end
      end
      MODE_SCAN: begin
        if (!cur_vld || take_out) begin
          next_vld = 1'b1;
          // An index left over from an out-of-range decode restarts the sweep at 0.
          if (!dec_in_range) begin
            next_idx = '0;
            next_num = OUT_W'(1);
          end else if (!cur_vld) begin
            next_num = dec_onehot;
          end else if (cur_idx == IN_W'(OUT_W - 1)) begin
            next_idx  = '0;
            next_num  = rot_num;
            next_wrap = 1'b1;
          end else begin
            next_idx = cur_idx + IN_W'(1);
            next_num = rot_num;
          end
        end
      end
      MODE_CLEAR: begin
        next_num = '0;
        next_idx = '0;
        next_vld = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_num  <= '0;
      cur_idx  <= '0;
      cur_vld  <= 1'b0;
      cur_wrap <= 1'b0;
      cur_err  <= 1'b0;
    end else begin
      cur_num  <= next_num;
      cur_idx  <= next_idx;
      cur_vld  <= next_vld;
      cur_wrap <= next_wrap;
      cur_err  <= next_err;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = cur_vld;
  assign bus.res_num   = cur_num;
  assign bus.res_idx   = cur_idx;
  assign bus.wrap      = cur_wrap;
  assign bus.err       = cur_err;

endmodule

// File: tb/tb_onehot_dec_seq.sv
module tb_onehot_dec_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] d_mode = 2'b00;
  logic       d_iv = 1'b0;
  logic [2:0] d_src = 3'd0;
  logic       d_ordy = 1'b0;

  onehot_dec_seq_if #(.OUT_W(8)) b8 ();
  onehot_dec_seq_if #(.OUT_W(6)) b6 ();

  assign b8.mode = d_mode;  assign b8.in_valid = d_iv;
  assign b8.src_num = d_src; assign b8.out_ready = d_ordy;
  assign b6.mode = d_mode;  assign b6.in_valid = d_iv;
  assign b6.src_num = d_src; assign b6.out_ready = d_ordy;

  onehot_dec_seq #(.OUT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  onehot_dec_seq #(.OUT_W(6)) dut6 (.clk(clk), .rst_n(rst_n), .bus(b6.slave));

  int total = 0;
  int bad = 0;

  // Reference model, index 0 = 8-wide instance, index 1 = 6-wide instance.
  int W[2] = '{8, 6};
  int m_idx[2] = '{0, 0};
  int m_num[2] = '{0, 0};
  bit m_v[2] = '{0, 0};
  bit m_wrap[2] = '{0, 0};
  bit m_err[2] = '{0, 0};

  function automatic bit exp_rdy(int k);
    return (rst_n === 1'b1) && (d_mode == 2'b00) && (!m_v[k] || d_ordy);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idx[k] = 0; m_num[k] = 0; m_v[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
    end
  endfunction

  function automatic void model_step(int k);
    bit rdy, hs;
    rdy = exp_rdy(k);
    hs = m_v[k] && d_ordy;
    m_wrap[k] = 0;
    m_err[k] = 0;
    case (d_mode)
      2'b00: begin
        if (d_iv && rdy) begin
          m_idx[k] = int'(d_src);
          m_num[k] = (m_idx[k] < W[k]) ? (1 << m_idx[k]) : 0;
          m_err[k] = (m_idx[k] >= W[k]);
          m_v[k] = 1;
        end else if (hs) begin
          m_v[k] = 0;
        end
      end
      2'b01: begin
        if (!m_v[k]) begin
          m_v[k] = 1;
          if (m_idx[k] >= W[k]) m_idx[k] = 0;
          m_num[k] = 1 << m_idx[k];
        end else if (hs) begin
          if (m_idx[k] >= W[k]) m_idx[k] = 0;
          else begin
            m_wrap[k] = (m_idx[k] == W[k] - 1);
            m_idx[k] = (m_idx[k] + 1) % W[k];
          end
          m_num[k] = 1 << m_idx[k];
        end
      end
      2'b10: begin
        m_idx[k] = 0; m_num[k] = 0; m_v[k] = 0;
      end
      default: ;
    endcase
  endfunction

  task automatic drive(input int m, input int iv, input int s, input int r);
    d_mode = 2'(m); d_iv = 1'(iv); d_src = 3'(s); d_ordy = 1'(r);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1, 3, 1);
    #3;
    total++;
    if (b8.res_num !== 8'd0 || b8.res_idx !== 3'd0 || b8.out_valid !== 1'b0 ||
        b8.wrap !== 1'b0 || b8.err !== 1'b0 || b8.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset8 num=%b idx=%0d vld=%b wrap=%b err=%b rdy=%b required all 0",
               b8.res_num, b8.res_idx, b8.out_valid, b8.wrap, b8.err, b8.in_ready);
    end
    total++;
    if (b6.res_num !== 6'd0 || b6.out_valid !== 1'b0 || b6.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset6 num=%b vld=%b rdy=%b required all 0", b6.res_num, b6.out_valid, b6.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_decode_stream();
    int seq[4] = '{3, 6, 0, 4};
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, seq[i], 1);
      #1;
      total++;
      if (b8.in_ready !== 1'b1) begin
        bad++; $display("FAIL stream_rdy i=%0d got=%b required=1", i, b8.in_ready);
      end
      step();
      e = 8'(1 << seq[i]);
      total++;
      if (b8.res_num !== e || b8.out_valid !== 1'b1 || b8.err !== 1'b0) begin
        bad++;
        $display("FAIL stream_out i=%0d num=%b vld=%b err=%b required num=%b vld=1 err=0",
                 i, b8.res_num, b8.out_valid, b8.err, e);
      end
    end
    drive(0, 0, 0, 1);
    step();
    total++;
    if (b8.out_valid !== 1'b0) begin
      bad++; $display("FAIL stream_drain vld=%b required=0", b8.out_valid);
    end
  endtask

  task automatic test_backpressure();
    drive(0, 1, 5, 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 2, 0);
      #1;
      total++;
      if (b8.in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_rdy i=%0d got=%b required=0", i, b8.in_ready);
      end
      step();
      total++;
      if (b8.res_num !== 8'b00100000 || b8.res_idx !== 3'd5 || b8.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold i=%0d num=%b idx=%0d vld=%b required 00100000/5/1",
                 i, b8.res_num, b8.res_idx, b8.out_valid);
      end
    end
    drive(0, 1, 2, 1);
    #1;
    total++;
    if (b8.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release_rdy got=%b required=1", b8.in_ready);
    end
    step();
    total++;
    if (b8.res_num !== 8'b00000100) begin
      bad++; $display("FAIL bp_next num=%b required=00000100", b8.res_num);
    end
    drive(0, 0, 0, 1);
    step();
  endtask

  task automatic test_err_scan();
    drive(0, 1, 7, 1);
    step();
    total++;
    if (b6.res_num !== 6'd0 || b6.res_idx !== 3'd7 || b6.err !== 1'b1 || b6.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL err_decode num=%b idx=%0d err=%b vld=%b required 000000/7/1/1",
               b6.res_num, b6.res_idx, b6.err, b6.out_valid);
    end
    total++;
    if (b8.err !== 1'b0 || b8.res_num !== 8'b10000000) begin
      bad++; $display("FAIL err_inrange8 err=%b num=%b required 0/10000000", b8.err, b8.res_num);
    end
    drive(1, 0, 0, 1);
    step();
    total++;
    if (b6.res_idx !== 3'd0 || b6.res_num !== 6'b000001 || b6.err !== 1'b0 || b6.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL err_to_scan idx=%0d num=%b err=%b vld=%b required 0/000001/0/1",
               b6.res_idx, b6.res_num, b6.err, b6.out_valid);
    end
  endtask

  task automatic test_scan_wrap();
    int ei[3] = '{5, 0, 1};
    logic [5:0] en[3] = '{6'b100000, 6'b000001, 6'b000010};
    logic ew[3] = '{1'b0, 1'b1, 1'b0};
    drive(0, 1, 4, 1);
    step();
    total++;
    if (b6.res_idx !== 3'd4 || b6.res_num !== 6'b010000 || b6.wrap !== 1'b0) begin
      bad++;
      $display("FAIL scan_start idx=%0d num=%b wrap=%b required 4/010000/0", b6.res_idx, b6.res_num, b6.wrap);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1);
      step();
      total++;
      if (b6.res_idx !== 3'(ei[i]) || b6.res_num !== en[i] || b6.wrap !== ew[i]) begin
        bad++;
        $display("FAIL scan_step i=%0d idx=%0d num=%b wrap=%b required %0d/%b/%b",
                 i, b6.res_idx, b6.res_num, b6.wrap, ei[i], en[i], ew[i]);
      end
    end
  endtask

  task automatic test_clear_hold();
    drive(1, 0, 0, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 5, 0);
      step();
      total++;
      if (b6.res_idx !== 3'd2 || b6.res_num !== 6'b000100 || b6.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL scan_stall i=%0d idx=%0d num=%b vld=%b required 2/000100/1",
                 i, b6.res_idx, b6.res_num, b6.out_valid);
      end
    end
    drive(2, 0, 0, 0);
    step();
    total++;
    if (b6.res_num !== 6'd0 || b6.res_idx !== 3'd0 || b6.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL clear num=%b idx=%0d vld=%b required 0/0/0", b6.res_num, b6.res_idx, b6.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(3, 1, 3, 1);
      #1;
      total++;
      if (b6.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_rdy i=%0d got=%b required=0", i, b6.in_ready);
      end
      step();
      total++;
      if (b6.res_num !== 6'd0 || b6.res_idx !== 3'd0 || b6.out_valid !== 1'b0) begin
        bad++;
        $display("FAIL hold_idle i=%0d num=%b idx=%0d vld=%b required 0/0/0",
                 i, b6.res_num, b6.res_idx, b6.out_valid);
      end
    end
    drive(0, 1, 3, 0);
    step();
    drive(3, 0, 0, 1);
    step();
    total++;
    if (b6.out_valid !== 1'b1 || b6.res_idx !== 3'd3 || b6.res_num !== 6'b001000) begin
      bad++;
      $display("FAIL hold_pending vld=%b idx=%0d num=%b required 1/3/001000",
               b6.out_valid, b6.res_idx, b6.res_num);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 4, 1);
    step();
    total++;
    if (b8.res_num !== 8'b00010000 || b8.out_valid !== 1'b1) begin
      bad++; $display("FAIL arst_pre num=%b vld=%b required 00010000/1", b8.res_num, b8.out_valid);
    end
    drive(0, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    total++;
    if (b8.res_num !== 8'd0 || b8.res_idx !== 3'd0 || b8.out_valid !== 1'b0 || b8.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL arst_now num=%b idx=%0d vld=%b rdy=%b required 0/0/0/0",
               b8.res_num, b8.res_idx, b8.out_valid, b8.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 1, 1, 1);
    step();
    total++;
    if (b8.res_num !== 8'b00000010 || b8.out_valid !== 1'b1) begin
      bad++; $display("FAIL arst_after num=%b vld=%b required 00000010/1", b8.res_num, b8.out_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] o_num[2];
    logic [2:0] o_idx[2];
    logic o_v[2], o_w[2], o_e[2], o_r[2];
    int r, m;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      m = (r < 10) ? 0 : (r < 16) ? 1 : (r < 17) ? 2 : 3;
      drive(m, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      #1;
      o_r[0] = b8.in_ready;
      o_r[1] = b6.in_ready;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_r[k] !== exp_rdy(k)) begin
          bad++; $display("FAIL rand_rdy n=%0d w=%0d got=%b required=%b", n, W[k], o_r[k], exp_rdy(k));
        end
      end
      step();
      o_num[0] = b8.res_num;          o_num[1] = {2'b00, b6.res_num};
      o_idx[0] = b8.res_idx;          o_idx[1] = b6.res_idx;
      o_v[0] = b8.out_valid;          o_v[1] = b6.out_valid;
      o_w[0] = b8.wrap;               o_w[1] = b6.wrap;
      o_e[0] = b8.err;                o_e[1] = b6.err;
      for (int k = 0; k < 2; k++) begin
        total++;
        if (o_num[k] !== 8'(m_num[k]) || o_idx[k] !== 3'(m_idx[k]) || o_v[k] !== m_v[k] ||
            o_w[k] !== m_wrap[k] || o_e[k] !== m_err[k]) begin
          bad++;
          $display("FAIL rand_out n=%0d w=%0d num=%b idx=%0d vld=%b wrap=%b err=%b required %b/%0d/%b/%b/%b",
                   n, W[k], o_num[k], o_idx[k], o_v[k], o_w[k], o_e[k],
                   8'(m_num[k]), m_idx[k], m_v[k], m_wrap[k], m_err[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode_stream();
    test_backpressure();
    test_err_scan();
    test_scan_wrap();
    test_clear_hold();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_dec_seq.md
Name: onehot_dec_seq

Overview:
Parametrised, registered successor to the 3-to-8 combinational one-hot decoder. It converts a binary index into a one-hot vector of OUT_W bits. The output sits behind a valid/ready handshake. The block adds a self-running scan mode that walks the hot bit and a synchronous clear. It is used wherever a registered select line (bank, channel, row) must be driven either directly or by round-robin sweep.

Parameters:
- OUT_W, default 8, one-hot output width; minimum 2; need not be a power of two.
- IN_W, localparam = $clog2(OUT_W), binary index width; not overridable.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- mode  in  2  operating mode: 00 DECODE, 01 SCAN, 10 CLEAR, 11 HOLD
- in_valid  in  1  src_num valid (DECODE only)
- in_ready  out  1  block can accept src_num this cycle
- src_num  in  IN_W  binary index to decode
- out_valid  out  1  res_num/res_idx valid
- out_ready  in  1  consumer accepts output this cycle
- res_num  out  OUT_W  registered one-hot result
- res_idx  out  IN_W  binary index of the hot bit in res_num
- wrap  out  1  one-cycle pulse: scan advanced from OUT_W-1 to 0
- err  out  1  one-cycle pulse: accepted src_num >= OUT_W

Behaviour:
- Reset (rst_n low, asynchronous): res_num=0, res_idx=0, out_valid=0, wrap=0, err=0. in_ready reads 0 while rst_n is low.
- Handshakes:
  - in_ready = (mode==00) && (!out_valid || out_ready). This is combinational.
  - Output handshake occurs when out_valid && out_ready.
- DECODE (00):
  - Input is accepted when in_valid && in_ready.
  - Next cycle: res_idx=src_num, res_num=1<<src_num, out_valid=1. Latency 1 cycle.
  - Throughput: 1 per cycle when out_ready is held high.
  - If src_num >= OUT_W: it is still accepted, res_num=0, res_idx=src_num, out_valid=1, and err pulses in the same cycle the result appears.
  - While out_valid && !out_ready, res_num/res_idx are held stable.
  - A handshake with no new input clears out_valid.
- SCAN (01):
  - src_num and in_valid are ignored; in_ready=0.
  - If out_valid=0: next cycle out_valid=1, res_num=1<<res_idx. If res_idx >= OUT_W (left over from an err decode), it forces res_idx=0 and res_num=1.
  - On each output handshake: res_idx = (res_idx==OUT_W-1) ? 0 : res_idx+1, and res_num is rotated left by one within OUT_W bits.
  - wrap is 1 in the cycle the new index 0 appears from index OUT_W-1.
  - With out_ready=0 there is no advance and the output is held.
- CLEAR (10):
  - Next cycle: res_num=0, res_idx=0, out_valid=0.
  - This is unconditional, even if out_valid && !out_ready. The pending output is dropped, not flushed.
  - in_ready=0.
- HOLD (11): no state change, in_ready=0. out_valid is held, and a handshake in HOLD does NOT clear out_valid.
- Mode switches:
  - mode is sampled every cycle; no drain is required.
  - A pending DECODE result becomes the SCAN starting point.
  - SCAN to DECODE keeps the current output until handshaken.
- wrap and err are registered single-cycle pulses, 0 in all other cycles.
- No combinational path from src_num to res_num; res_num is a pure flop output.

Decomposition:
- Shared package onehot_pkg:
  - mode constants MODE_DECODE=2'b00, MODE_SCAN=2'b01, MODE_CLEAR=2'b10, MODE_HOLD=2'b11
  - mode_t 2-bit typedef
- One natural sub-module: onehot_dec, a combinational, parametrised (OUT_W) binary-to-one-hot decoder with a range flag.
  - Used for both the decode and the scan-reload paths.
  - Replaces the fixed 3-to-8 decoder.

Test Plan:
1. OUT_W=8, DECODE, out_ready=1; src_num 3,6,0,4 on consecutive cycles with in_valid=1 -> res_num 00001000, 01000000, 00000001, 00010000, each one cycle after input; out_valid high 4 cycles; err never set.
2. OUT_W=8, DECODE, src_num=5 accepted, out_ready=0 for 3 cycles -> res_num=00100000 held, in_ready=0 throughout; out_ready=1 then accepts src_num=2 -> res_num=00000100 next cycle.
3. OUT_W=6, DECODE src_num=7 -> res_num=000000, res_idx=7, err pulse 1 cycle; switch to SCAN -> res_idx=0, res_num=000001.
4. OUT_W=6, SCAN from idx 4, out_ready=1 -> res_idx 4,5,0,1; res_num 010000,100000,000001,000010; wrap high only with idx 0.
5. SCAN at idx 2 with out_ready=0, then mode=CLEAR for 1 cycle -> next cycle res_num=0, res_idx=0, out_valid=0; mode=HOLD 3 cycles -> no change.
6. Mid-DECODE (out_valid=1, res_num=00010000), assert rst_n=0 between clock edges -> outputs zero immediately without a clock edge; after release, first accepted src_num=1 -> 00000010.
